// File: rtl/led_pkg.sv
// ---------------------------------------------------------------------------
// led_pkg
//   Shared definitions for the LED pattern sequencer:
//     - LED bank width
//     - pattern mode encodings (COUNT, CHASE, BOUNCE, BLINK)
//     - bounce direction encoding
//     - initial pattern loaded when a mode is entered
//     - helpers for the mode advance order and the per-mode initial pattern
// ---------------------------------------------------------------------------
package led_pkg;

    localparam int LED_WIDTH = 8;

    typedef enum logic [1:0] {
        MODE_COUNT  = 2'd0,
        MODE_CHASE  = 2'd1,
        MODE_BOUNCE = 2'd2,
        MODE_BLINK  = 2'd3
    } mode_t;

    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } dir_t;

    localparam logic [LED_WIDTH-1:0] INIT_COUNT  = 8'h00;
    localparam logic [LED_WIDTH-1:0] INIT_CHASE  = 8'h01;
    localparam logic [LED_WIDTH-1:0] INIT_BOUNCE = 8'h01;
    localparam logic [LED_WIDTH-1:0] INIT_BLINK  = 8'h00;

    // Button presses walk the modes in a fixed ring.
    function automatic mode_t next_mode(input mode_t m);
        mode_t n;
        case (m)
            MODE_COUNT:  n = MODE_CHASE;
            MODE_CHASE:  n = MODE_BOUNCE;
            MODE_BOUNCE: n = MODE_BLINK;
            MODE_BLINK:  n = MODE_COUNT;
            default:     n = MODE_COUNT;
        endcase
        return n;
    endfunction

    function automatic logic [LED_WIDTH-1:0] init_pattern(input mode_t m);
        logic [LED_WIDTH-1:0] p;
        case (m)
            MODE_COUNT:  p = INIT_COUNT;
            MODE_CHASE:  p = INIT_CHASE;
            MODE_BOUNCE: p = INIT_BOUNCE;
            MODE_BLINK:  p = INIT_BLINK;
            default:     p = INIT_COUNT;
        endcase
        return p;
    endfunction

endpackage

// File: rtl/led_sequencer_if.sv
// ---------------------------------------------------------------------------
// led_sequencer_if
//   Board-side signal bundle of the LED sequencer.
//     BUTTON      raw push-button, high = pressed (async to clk)
//     ENABLE      high = run; low = freeze prescaler and pattern
//     MODE        registered current mode (0 COUNT, 1 CHASE, 2 BOUNCE, 3 BLINK)
//     LED7..LED0  registered pattern bits 7..0
//     dbg_mode    live mode FSM state (one clock ahead of MODE)
//     dbg_dir     live bounce direction (0 up, 1 down)
//   There is no handshake on this bundle: inputs are level signals sampled
//   every clock, outputs are registered levels updated every clock.
//   modport slave  : the sequencer
//   modport master : whatever drives the button/enable and watches the LEDs
// ---------------------------------------------------------------------------
interface led_sequencer_if;
    logic       BUTTON;
    logic       ENABLE;
    logic [1:0] MODE;
    logic       LED7;
    logic       LED6;
    logic       LED5;
    logic       LED4;
    logic       LED3;
    logic       LED2;
    logic       LED1;
    logic       LED0;
    logic [1:0] dbg_mode;
    logic       dbg_dir;

    modport slave (
        input  BUTTON, ENABLE,
        output MODE, LED7, LED6, LED5, LED4, LED3, LED2, LED1, LED0,
        output dbg_mode, dbg_dir
    );

    modport master (
        output BUTTON, ENABLE,
        input  MODE, LED7, LED6, LED5, LED4, LED3, LED2, LED1, LED0,
        input  dbg_mode, dbg_dir
    );
endinterface

// File: rtl/button_debounce.sv
// ---------------------------------------------------------------------------
// button_debounce
//   Turns a raw, bouncing push-button into a single-clock press pulse.
//   Ports:
//     clk       clock, rising edge
//     NOTRESET  asynchronous active-low reset
//     BUTTON    raw button level, high = pressed, asynchronous to clk
//     PRESS     one-clock pulse on each accepted press (registered)
//   Parameter:
//     DEBOUNCE_BITS  the synced level must disagree with the accepted level
//                    for 2^DEBOUNCE_BITS consecutive clocks to be accepted
//   Latency from a clean BUTTON rise to PRESS is 2 + 2^DEBOUNCE_BITS clocks.
// ---------------------------------------------------------------------------
module button_debounce #(
    parameter int DEBOUNCE_BITS = 16
) (
    input  logic clk,
    input  logic NOTRESET,
    input  logic BUTTON,
    output logic PRESS
);

    localparam logic [DEBOUNCE_BITS-1:0] CNT_ONE = DEBOUNCE_BITS'(1);

    logic                     sync_a;
    logic                     sync_b;
    logic [DEBOUNCE_BITS-1:0] stable_cnt;
    logic                     level;

    // Two-flop synchroniser for the asynchronous button.
    always_ff @(posedge clk or negedge NOTRESET) begin
        if (!NOTRESET) begin
            sync_a <= 1'b0;
            sync_b <= 1'b0;
        end else begin
            sync_a <= BUTTON;
            sync_b <= sync_a;
        end
    end

    // The counter measures how long the synced level has disagreed with the
    // accepted level. Any agreement (a bounce back) restarts the count, so only
    // an unbroken run of 2^DEBOUNCE_BITS clocks flips the accepted level.
    // PRESS fires on the clock where a new high level is accepted; accepting a
    // release produces no pulse.
    always_ff @(posedge clk or negedge NOTRESET) begin
        if (!NOTRESET) begin
            stable_cnt <= '0;
            level      <= 1'b0;
            PRESS      <= 1'b0;
        end else begin
            PRESS <= 1'b0;
            if (sync_b == level) begin
                stable_cnt <= '0;
            end else if (stable_cnt == '1) begin
                level      <= sync_b;
                PRESS      <= sync_b;
                stable_cnt <= '0;
            end else begin
                stable_cnt <= stable_cnt + CNT_ONE;
            end
        end
    end

endmodule

// File: rtl/led_sequencer.sv
// ---------------------------------------------------------------------------
// led_sequencer
//   Drives the 8-LED bank from a selectable pattern sequencer. A prescaler
//   produces a slow step tick; a debounced button cycles the pattern mode
//   COUNT -> CHASE -> BOUNCE -> BLINK -> COUNT.
//   Ports:
//     clk       clock, all flops on its rising edge
//     NOTRESET  asynchronous active-low reset
//     bus       led_sequencer_if.slave: BUTTON, ENABLE in; MODE, LED7..LED0,
//               dbg_mode, dbg_dir out
//   Parameters:
//     PRESCALE_BITS  one step tick every 2^PRESCALE_BITS enabled clocks
//     DEBOUNCE_BITS  button debounce length, see button_debounce
//   MODE and LEDs are registered copies of the mode/pattern registers and so
//   trail them by one clock.
// ---------------------------------------------------------------------------
module led_sequencer
    import led_pkg::*;
#(
    parameter int PRESCALE_BITS = 18,
    parameter int DEBOUNCE_BITS = 16
) (
    input  logic            clk,
    input  logic            NOTRESET,
    led_sequencer_if.slave  bus
);

    localparam logic [PRESCALE_BITS-1:0] PRE_ONE = PRESCALE_BITS'(1);

    logic [PRESCALE_BITS-1:0] prescale;
    logic                     tick;
    logic                     press;

    mode_t                    mode;
    dir_t                     dir;
    logic [LED_WIDTH-1:0]     pattern;

    logic [LED_WIDTH-1:0]     led_q;
    logic [1:0]               mode_q;

    // ------------------------------------------------------------------
    // Button path
    // ------------------------------------------------------------------
    button_debounce #(
        .DEBOUNCE_BITS (DEBOUNCE_BITS)
    ) u_debounce (
        .clk      (clk),
        .NOTRESET (NOTRESET),
        .BUTTON   (bus.BUTTON),
        .PRESS    (press)
    );

    // ------------------------------------------------------------------
    // Prescaler: counts enabled clocks; the tick marks the enabled clock on
    // which the count wraps from all-ones to zero.
    // ------------------------------------------------------------------
    assign tick = bus.ENABLE && (prescale == '1);

    always_ff @(posedge clk or negedge NOTRESET) begin
        if (!NOTRESET) begin
            prescale <= '0;
        end else if (bus.ENABLE) begin
            prescale <= prescale + PRE_ONE;
        end
    end

    // ------------------------------------------------------------------
    // Mode FSM with pattern and bounce direction.
    // A press always wins over a tick in the same clock: the mode advances,
    // the new mode's initial pattern loads and the tick is dropped. Presses
    // are honoured even while ENABLE is low; ticks never occur then.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge NOTRESET) begin
        if (!NOTRESET) begin
            mode    <= MODE_COUNT;
            dir     <= DIR_UP;
            pattern <= INIT_COUNT;
        end else if (press) begin
            mode    <= next_mode(mode);
            pattern <= init_pattern(next_mode(mode));
            dir     <= DIR_UP;
        end else if (tick) begin
            case (mode)
                MODE_COUNT: begin
                    pattern <= pattern + 8'h01;
                end
                MODE_CHASE: begin
                    pattern <= {pattern[LED_WIDTH-2:0], pattern[LED_WIDTH-1]};
                end
                MODE_BOUNCE: begin
                    // Turn around on reaching an end so the end value is shown
                    // only once per sweep.
                    if (dir == DIR_UP) begin
                        if (pattern == 8'h80) begin
                            dir     <= DIR_DOWN;
                            pattern <= 8'h40;
                        end else begin
                            pattern <= pattern << 1;
                        end
                    end else begin
                        if (pattern == 8'h01) begin
                            dir     <= DIR_UP;
                            pattern <= 8'h02;
                        end else begin
                            pattern <= pattern >> 1;
                        end
                    end
                end
                MODE_BLINK: begin
                    pattern <= ~pattern;
                end
                default: begin
                    mode    <= MODE_COUNT;
                    dir     <= DIR_UP;
                    pattern <= INIT_COUNT;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Output registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge NOTRESET) begin
        if (!NOTRESET) begin
            led_q  <= '0;
            mode_q <= 2'd0;
        end else begin
            led_q  <= pattern;
            mode_q <= mode;
        end
    end

    assign bus.MODE     = mode_q;
    assign bus.LED7     = led_q[7];
    assign bus.LED6     = led_q[6];
    assign bus.LED5     = led_q[5];
    assign bus.LED4     = led_q[4];
    assign bus.LED3     = led_q[3];
    assign bus.LED2     = led_q[2];
    assign bus.LED1     = led_q[1];
    assign bus.LED0     = led_q[0];
    assign bus.dbg_mode = mode;
    assign bus.dbg_dir  = dir;

endmodule

// File: tb/tb_led_sequencer.sv
// ---------------------------------------------------------------------------
// tb_led_sequencer
//   Directed scenarios followed by randomised button/enable activity, all
//   checked every clock against a behavioural model of the sequencer.
// ---------------------------------------------------------------------------
module tb_led_sequencer;

    localparam int PB = 3;
    localparam int DB = 2;
    localparam int TICK_PERIOD = 1 << PB;
    localparam int STABLE_LEN  = 1 << DB;

    // ------------------------------------------------------------------
    // Clock / reset
    // ------------------------------------------------------------------
    logic clk = 1'b0;
    logic NOTRESET = 1'b0;
    always #5 clk = ~clk;

    led_sequencer_if bus_if ();

    led_sequencer #(
        .PRESCALE_BITS (PB),
        .DEBOUNCE_BITS (DB)
    ) dut (
        .clk      (clk),
        .NOTRESET (NOTRESET),
        .bus      (bus_if)
    );

    int compare_n = 0;
    int fail_n    = 0;

    // ------------------------------------------------------------------
    // Behavioural model
    //   Ticks: every TICK_PERIOD-th enabled clock.
    //   Button: a raw sample reaches the debouncer two clocks late; a run of
    //   STABLE_LEN samples disagreeing with the accepted level flips it, and a
    //   flip to high becomes a press that acts on the following clock.
    //   Bounce: position 0..13 around a 14-step ring mapped to a one-hot LED.
    // ------------------------------------------------------------------
    int         en_count;
    int         samples[$];
    int         run_len;
    int         level;
    int         press_pend;
    int         mode_i;
    int         pat;
    int         bpos;
    logic [7:0] exp_led;
    logic [1:0] exp_mode;

    function automatic int init_of(input int m);
        return (m == 1 || m == 2) ? 1 : 0;
    endfunction

    task automatic model_reset();
        en_count   = 0;
        samples    = {};
        samples.push_back(0);
        samples.push_back(0);
        run_len    = 0;
        level      = 0;
        press_pend = 0;
        mode_i     = 0;
        pat        = 0;
        bpos       = 0;
        exp_led    = 8'h00;
        exp_mode   = 2'd0;
    endtask

    task automatic model_step();
        int tick;
        int s;
        int new_press;
        exp_led  = pat[7:0];
        exp_mode = mode_i[1:0];
        tick = (bus_if.ENABLE === 1'b1) && ((en_count % TICK_PERIOD) == TICK_PERIOD - 1);
        if (bus_if.ENABLE === 1'b1) en_count++;
        if (press_pend != 0) begin
            mode_i = (mode_i + 1) % 4;
            pat    = init_of(mode_i);
            bpos   = 0;
        end else if (tick != 0) begin
            case (mode_i)
                0: pat = (pat + 1) % 256;
                1: pat = ((pat * 2) % 256) + (pat / 128);
                2: begin
                    bpos = (bpos + 1) % 14;
                    pat  = 1 << ((bpos < 8) ? bpos : 14 - bpos);
                end
                default: pat = 255 - pat;
            endcase
        end
        s = samples.pop_front();
        samples.push_back((bus_if.BUTTON === 1'b1) ? 1 : 0);
        new_press = 0;
        if (s != level) begin
            run_len++;
            if (run_len == STABLE_LEN) begin
                level     = s;
                new_press = s;
                run_len   = 0;
            end
        end else begin
            run_len = 0;
        end
        press_pend = new_press;
    endtask

    initial model_reset();

    always @(posedge clk or negedge NOTRESET) begin
        if (!NOTRESET) model_reset();
        else           model_step();
    end

    // ------------------------------------------------------------------
    // Checking helpers
    // ------------------------------------------------------------------
    function automatic logic [7:0] leds();
        return {bus_if.LED7, bus_if.LED6, bus_if.LED5, bus_if.LED4,
                bus_if.LED3, bus_if.LED2, bus_if.LED1, bus_if.LED0};
    endfunction

    task automatic check_val(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
        compare_n++;
        assert (obs === exp_v) else begin
            fail_n++;
            $error("FAIL %s: observed 0x%02h expected 0x%02h", tag, obs, exp_v);
        end
    endtask

    // One clock, then compare LEDs and MODE with the model.
    task automatic cycle(input string tag);
        @(negedge clk);
        check_val({tag, "_led"}, leds(), exp_led);
        check_val({tag, "_mode"}, {6'b0, bus_if.MODE}, {6'b0, exp_mode});
    endtask

    task automatic press_button(input string tag, input int hold);
        bus_if.BUTTON = 1'b1;
        repeat (hold) cycle(tag);
        bus_if.BUTTON = 1'b0;
    endtask

    // ------------------------------------------------------------------
    // Directed + random sequence
    // ------------------------------------------------------------------
    logic [7:0] frozen;

    initial begin
        bus_if.BUTTON = 1'b0;
        bus_if.ENABLE = 1'b0;
        NOTRESET      = 1'b0;
        repeat (3) @(negedge clk);
        check_val("reset_led", leds(), 8'h00);
        check_val("reset_mode", {6'b0, bus_if.MODE}, 8'h00);

        // COUNT: 20 ticks, one every 8 clocks
        NOTRESET      = 1'b1;
        bus_if.ENABLE = 1'b1;
        repeat (20 * TICK_PERIOD + 1) cycle("count");
        check_val("count_20_ticks", leds(), 8'h14);

        // One long press -> CHASE, then wrap through 0x80 -> 0x01
        press_button("press_chase", 10);
        repeat (10 * TICK_PERIOD) cycle("chase");
        check_val("chase_mode", {6'b0, bus_if.MODE}, 8'h01);

        // BOUNCE sweep
        press_button("press_bounce", 10);
        repeat (16 * TICK_PERIOD) cycle("bounce");
        check_val("bounce_mode", {6'b0, bus_if.MODE}, 8'h02);

        // Short glitch must not count as a press
        press_button("glitch", 3);
        repeat (12) cycle("glitch_after");
        check_val("glitch_mode", {6'b0, bus_if.MODE}, 8'h02);

        // Press landing on a tick clock: the press acts 7 clocks after the
        // button is raised, so raise it when that clock will carry a tick.
        for (int i = 0; i < TICK_PERIOD && (en_count % TICK_PERIOD) != 1; i++)
            cycle("align");
        press_button("press_on_tick", 10);
        check_val("press_on_tick_led", leds(), 8'h00);
        check_val("press_on_tick_mode", {6'b0, bus_if.MODE}, 8'h03);
        repeat (2 * TICK_PERIOD) cycle("blink");

        // ENABLE low freezes the LEDs
        bus_if.ENABLE = 1'b0;
        @(negedge clk);
        frozen = exp_led;
        repeat (50) begin
            cycle("freeze");
            check_val("freeze_hold", leds(), frozen);
        end

        // Press still accepted while frozen: BLINK -> COUNT
        press_button("press_frozen", 10);
        repeat (4) cycle("frozen_after");
        check_val("frozen_press_mode", {6'b0, bus_if.MODE}, 8'h00);
        check_val("frozen_press_led", leds(), 8'h00);

        // Randomised button and enable activity
        repeat (150) begin
            int len;
            bus_if.ENABLE = ($urandom_range(0, 3) != 0);
            bus_if.BUTTON = $urandom_range(0, 1);
            len = $urandom_range(1, 14);
            repeat (len) cycle("rand");
        end

        // Asynchronous reset between clock edges
        bus_if.BUTTON = 1'b0;
        bus_if.ENABLE = 1'b1;
        repeat (TICK_PERIOD + 3) cycle("pre_rst");
        @(negedge clk);
        #2 NOTRESET = 1'b0;
        #1;
        check_val("async_rst_led", leds(), 8'h00);
        check_val("async_rst_mode", {6'b0, bus_if.MODE}, 8'h00);
        @(negedge clk);
        NOTRESET = 1'b1;
        repeat (3 * TICK_PERIOD + 1) cycle("post_rst");
        check_val("post_rst_count", leds(), 8'h03);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compare_n, fail_n);
        $finish;
    end

endmodule
